// File: rtl/i2s_rx_slave.sv
// ---------------------------------------------------------------------------
// i2s_rx_slave
//
// I2S receiver operating as a bit-clock slave. The external SCK/WS/SD lines
// are oversampled in the clk domain; every protocol action happens on a
// detected SCK rising edge. Left and right words are assembled MSB first,
// paired (left then right), and presented on a valid/ready output port.
//
// Parameters
//   DATA_W        sample width in bits (16..32)
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   i2s_sck       external bit clock (asynchronous, at most clk/8)
//   i2s_ws        word select: 0 = left, 1 = right
//   i2s_sd        serial data, MSB first
//   sample_left   left sample of the presented pair
//   sample_right  right sample of the presented pair
//   sample_valid  a stereo pair is presented
//   sample_ready  consumer accepts the presented pair
//   overflow      one-cycle pulse when a completed pair is dropped
//   frame_err     one-cycle pulse when a word ends short
// ---------------------------------------------------------------------------
module i2s_rx_slave #(
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2s_sck,
    input  logic              i2s_ws,
    input  logic              i2s_sd,
    output logic [DATA_W-1:0] sample_left,
    output logic [DATA_W-1:0] sample_right,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              overflow,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // -----------------------------------------------------------------------
    // Input synchronizers. SCK, WS and SD all see the same two-flop delay so
    // the WS/SD values observed at a detected edge belong to that edge.
    // -----------------------------------------------------------------------
    logic [1:0] sck_sync;
    logic [1:0] ws_sync;
    logic [1:0] sd_sync;
    logic       sck_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, like real hardware.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync <= '0;
            ws_sync  <= '0;
            sd_sync  <= '0;
            sck_prev <= 1'b0;
        end else begin
            sck_sync <= {sck_sync[0], i2s_sck};
            ws_sync  <= {ws_sync[0], i2s_ws};
            sd_sync  <= {sd_sync[0], i2s_sd};
            sck_prev <= sck_sync[1];
        end
    end

    logic sck_rise;
    logic ws_s;
    logic sd_s;
    logic ws_prev;
    logic boundary;

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign ws_s     = ws_sync[1];
    assign sd_s     = sd_sync[1];
    // A boundary is the first edge on which WS differs from the previous edge.
    assign boundary = sck_rise & (ws_s != ws_prev);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ws_prev <= 1'b0;
        end else if (sck_rise) begin
            ws_prev <= ws_s;
        end
    end

    // -----------------------------------------------------------------------
    // Word framing FSM
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0]  bitcnt;
    logic [DATA_W-1:0] shreg;
    logic              chan;

    logic do_shift;
    logic do_commit;
    logic do_restart;
    logic do_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every combinational output gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_next = state;
        do_shift   = 1'b0;
        do_commit  = 1'b0;
        do_restart = 1'b0;
        do_err     = 1'b0;

        if (sck_rise) begin
            case (state)
                IDLE: begin
                    if (boundary) begin
                        do_restart = 1'b1;
                        state_next = SHIFT;
                    end
                end

                SHIFT: begin
                    if (!boundary) begin
                        do_shift = 1'b1;
                        if (bitcnt >= LAST_BIT) begin
                            do_commit  = 1'b1;
                            state_next = HOLD;
                        end
                    end else if (bitcnt >= LAST_BIT) begin
                        // Slot exactly DATA_W wide: the LSB arrives on the
                        // boundary edge itself, so take it, commit, restart.
                        do_shift   = 1'b1;
                        do_commit  = 1'b1;
                        do_restart = 1'b1;
                    end else begin
                        do_err     = 1'b1;
                        do_restart = 1'b1;
                    end
                end

                HOLD: begin
                    // Slot padding beyond DATA_W bits is ignored.
                    if (boundary) begin
                        do_restart = 1'b1;
                        state_next = SHIFT;
                    end
                end

                default: state_next = IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0] word;
    assign word = {shreg[DATA_W-2:0], sd_s};

    // NOTE: the shift register and holding register are reset too; they are
    // only a few flops and reset keeps simulation free of X on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg  <= '0;
            bitcnt <= '0;
            chan   <= 1'b0;
        end else begin
            if (do_shift) begin
                shreg  <= word;
                bitcnt <= (bitcnt == FULL) ? FULL : bitcnt + CNT_W'(1);
            end
            // Restart wins over the increment on a boundary commit.
            if (do_restart) begin
                chan   <= ws_s;
                bitcnt <= '0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Channel pairing and output handshake
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] left_hold;
    logic              left_captured;
    logic              pair_form;

    assign pair_form = do_commit & chan & left_captured;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            left_hold     <= '0;
            left_captured <= 1'b0;
        end else if (do_err) begin
            left_captured <= 1'b0;
        end else if (do_commit) begin
            if (!chan) begin
                left_hold     <= word;
                left_captured <= 1'b1;
            end else begin
                // A right word either completes the pair or is an orphan;
                // in both cases the next pair must start with a new left.
                left_captured <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overflow     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            frame_err <= do_err;
            if (pair_form) begin
                if (!sample_valid || sample_ready) begin
                    // Free slot, or the presented pair is being taken this
                    // very cycle: load without a gap in sample_valid.
                    sample_left  <= left_hold;
                    sample_right <= word;
                    sample_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_slave.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx_slave
//
// Self-checking bench for i2s_rx_slave. Test tasks build an I2S bit stream
// slot by slot (SD lags WS by one bit clock, as on a real I2S bus), push the
// pairs they expect into a scoreboard queue, and play the stream out. A
// monitor pops the queue on every output handshake and compares.
// ---------------------------------------------------------------------------
module tb_i2s_rx_slave;

    localparam int DATA_W = 24;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              i2s_sck;
    logic              i2s_ws;
    logic              i2s_sd;
    logic [DATA_W-1:0] sample_left;
    logic [DATA_W-1:0] sample_right;
    logic              sample_valid;
    logic              sample_ready;
    logic              overflow;
    logic              frame_err;

    always #5 clk = ~clk;

    i2s_rx_slave #(.DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .i2s_sck      (i2s_sck),
        .i2s_ws       (i2s_ws),
        .i2s_sd       (i2s_sd),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overflow     (overflow),
        .frame_err    (frame_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    bit    ws_q[$];
    bit    sd_q[$];
    pair_t exp_q[$];
    pair_t exp_head;

    int   ovf_cnt;
    int   ferr_cnt;
    int   vcnt;
    int   mark_cyc;
    event mark_ev;
    int   lat;
    bit   lat_found;

    bit                hold_chk = 1'b0;
    logic [DATA_W-1:0] held_l;
    logic [DATA_W-1:0] held_r;

    // -----------------------------------------------------------------------
    // Output monitor: scoreboard pops, pulse counting, hold stability.
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (reset) begin
            hold_chk = 1'b0;
        end else begin
            if (overflow)     ovf_cnt++;
            if (frame_err)    ferr_cnt++;
            if (sample_valid) vcnt++;
            if (hold_chk) begin
                checks++;
                if (sample_valid !== 1'b1 || sample_left !== held_l || sample_right !== held_r) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%0b l=%h r=%h required valid=1 l=%h r=%h",
                             sample_valid, sample_left, sample_right, held_l, held_r);
                end
            end
            if (sample_valid && sample_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pair: got l=%h r=%h required no pair",
                             sample_left, sample_right);
                end else begin
                    exp_head = exp_q.pop_front();
                    if (sample_left !== exp_head.l || sample_right !== exp_head.r) begin
                        errors++;
                        $display("FAIL pair_data: got l=%h r=%h required l=%h r=%h",
                                 sample_left, sample_right, exp_head.l, exp_head.r);
                    end
                end
            end
            hold_chk = sample_valid && !sample_ready;
            held_l   = sample_left;
            held_r   = sample_right;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2);
    endtask

    task automatic clear_counts();
        ovf_cnt  = 0;
        ferr_cnt = 0;
        vcnt     = 0;
    endtask

    task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q.push_back(p);
    endtask

    // One slot of 'width' bit clocks on channel c: word MSB first, then pad.
    task automatic add_slot(input bit c, input logic [31:0] w, input int width, input bit pad);
        for (int k = 0; k < width; k++) begin
            ws_q.push_back(c);
            sd_q.push_back((k < DATA_W) ? w[DATA_W-1-k] : pad);
        end
    endtask

    // Plays the stream; SCK period is 10 clk. Optionally pulses reset before
    // edge rst_idx and signals mark_ev at the rising edge of mark_idx.
    task automatic send_stream(input int rst_idx, input int mark_idx);
        int n;
        n = ws_q.size();
        for (int i = 0; i < n; i++) begin
            if (i == rst_idx) begin
                reset = 1'b1;
                wait_clk(3);
                checks++;
                if ({sample_valid, overflow, frame_err} !== 3'b000) begin
                    errors++;
                    $display("FAIL rst_mid_ctrl: valid/ovf/ferr=%b required 000",
                             {sample_valid, overflow, frame_err});
                end
                checks++;
                if (sample_left !== '0 || sample_right !== '0) begin
                    errors++;
                    $display("FAIL rst_mid_data: l=%h r=%h required 0/0", sample_left, sample_right);
                end
                reset = 1'b0;
                wait_clk(2);
            end
            i2s_sck = 1'b0;
            i2s_ws  = ws_q[i];
            i2s_sd  = (i == 0) ? 1'b0 : sd_q[i-1];
            wait_clk(5);
            i2s_sck = 1'b1;
            if (i == mark_idx) begin
                mark_cyc = cyc;
                -> mark_ev;
            end
            wait_clk(5);
        end
        i2s_sck = 1'b0;
        ws_q.delete();
        sd_q.delete();
    endtask

    // -----------------------------------------------------------------------
    // Tests
    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset        = 1'b1;
        sample_ready = 1'b0;
        i2s_sck      = 1'b0;
        i2s_ws       = 1'b0;
        i2s_sd       = 1'b0;
        wait_clk(4);
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", sample_valid); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
        checks++;
        if (sample_left !== '0) begin errors++; $display("FAIL reset_left: got %h required 0", sample_left); end
        checks++;
        if (sample_right !== '0) begin errors++; $display("FAIL reset_right: got %h required 0", sample_right); end
        reset = 1'b0;
        wait_clk(4);
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b required 0", sample_valid); end
    endtask

    task automatic test_48fs();
        do_reset();
        clear_counts();
        sample_ready = 1'b1;
        add_slot(1'b1, 32'h0,        24, 1'b0);
        add_slot(1'b0, 32'hABCDEF,   24, 1'b0);
        add_slot(1'b1, 32'h123456,   24, 1'b0);
        add_slot(1'b0, 32'h0,        2,  1'b0);
        push_pair(24'hABCDEF, 24'h123456);
        send_stream(-1, -1);
        wait_clk(10);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fs48_pending: got %0d pairs left required 0", exp_q.size()); end
        checks++;
        if (vcnt != 1) begin errors++; $display("FAIL fs48_valid_pulses: got %0d required 1", vcnt); end
        checks++;
        if (ovf_cnt != 0 || ferr_cnt != 0) begin
            errors++; $display("FAIL fs48_flags: ovf=%0d ferr=%0d required 0/0", ovf_cnt, ferr_cnt);
        end
    endtask

    task automatic test_64fs_padding();
        do_reset();
        clear_counts();
        sample_ready = 1'b1;
        add_slot(1'b1, 32'h0,      32, 1'b1);
        add_slot(1'b0, 32'h800001, 32, 1'b1);
        add_slot(1'b1, 32'h7FFFFE, 32, 1'b1);
        add_slot(1'b0, 32'h0,      2,  1'b1);
        push_pair(24'h800001, 24'h7FFFFE);
        send_stream(-1, -1);
        wait_clk(10);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL fs64_pending: got %0d pairs left required 0", exp_q.size()); end
        checks++;
        if (vcnt != 1) begin errors++; $display("FAIL fs64_valid_pulses: got %0d required 1", vcnt); end
        checks++;
        if (ovf_cnt != 0 || ferr_cnt != 0) begin
            errors++; $display("FAIL fs64_flags: ovf=%0d ferr=%0d required 0/0", ovf_cnt, ferr_cnt);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        clear_counts();
        sample_ready = 1'b0;
        add_slot(1'b1, 32'h0,      24, 1'b0);
        add_slot(1'b0, 32'h111111, 24, 1'b0);
        add_slot(1'b1, 32'h222222, 24, 1'b0);
        add_slot(1'b0, 32'h333333, 24, 1'b0);
        add_slot(1'b1, 32'h444444, 24, 1'b0);
        add_slot(1'b0, 32'h0,      2,  1'b0);
        push_pair(24'h111111, 24'h222222);
        send_stream(-1, -1);
        wait_clk(10);
        checks++;
        if (sample_valid !== 1'b1 || sample_left !== 24'h111111 || sample_right !== 24'h222222) begin
            errors++;
            $display("FAIL ovf_held_pair: valid=%b l=%h r=%h required 1 111111 222222",
                     sample_valid, sample_left, sample_right);
        end
        checks++;
        if (ovf_cnt != 1) begin errors++; $display("FAIL ovf_pulses: got %0d required 1", ovf_cnt); end
        sample_ready = 1'b1;
        wait_clk(1);
        sample_ready = 1'b0;
        wait_clk(5);
        checks++;
        if (sample_valid !== 1'b0) begin errors++; $display("FAIL ovf_second_absent: valid=%b required 0", sample_valid); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_pending: got %0d pairs left required 0", exp_q.size()); end
    endtask

    task automatic test_frame_err();
        do_reset();
        clear_counts();
        sample_ready = 1'b1;
        add_slot(1'b1, 32'h0,      24, 1'b0);
        add_slot(1'b0, 32'h5A5A5A, 11, 1'b0);
        add_slot(1'b1, 32'h0F0F0F, 24, 1'b0);
        add_slot(1'b0, 32'hC0FFEE, 24, 1'b0);
        add_slot(1'b1, 32'h654321, 24, 1'b0);
        add_slot(1'b0, 32'h0,      2,  1'b0);
        push_pair(24'hC0FFEE, 24'h654321);
        send_stream(-1, -1);
        wait_clk(10);
        checks++;
        if (ferr_cnt != 1) begin errors++; $display("FAIL ferr_pulses: got %0d required 1", ferr_cnt); end
        checks++;
        if (vcnt != 1) begin errors++; $display("FAIL ferr_valid_pulses: got %0d required 1", vcnt); end
        checks++;
        if (exp_q.size() != 0 || ovf_cnt != 0) begin
            errors++; $display("FAIL ferr_pending: pairs left=%0d ovf=%0d required 0/0", exp_q.size(), ovf_cnt);
        end
    endtask

    // Deliberately no leading reset: the presented outputs from the previous
    // test are non-zero, so the mid-word reset must visibly clear them.
    task automatic test_reset_mid_word();
        clear_counts();
        sample_ready = 1'b1;
        add_slot(1'b1, 32'h0,      24, 1'b0);
        add_slot(1'b0, 32'hAAAAAA, 24, 1'b0);
        add_slot(1'b1, 32'hBBBBBB, 24, 1'b0);
        add_slot(1'b0, 32'h13579B, 24, 1'b0);
        add_slot(1'b1, 32'h2468AC, 24, 1'b0);
        add_slot(1'b0, 32'hFEDCBA, 24, 1'b0);
        add_slot(1'b1, 32'h0A0B0C, 24, 1'b0);
        push_pair(24'h13579B, 24'h2468AC);
        send_stream(60, -1);
        wait_clk(10);
        checks++;
        if (vcnt != 1) begin errors++; $display("FAIL rst_mid_pairs: got %0d valid cycles required 1", vcnt); end
        checks++;
        if (exp_q.size() != 0 || ovf_cnt != 0) begin
            errors++; $display("FAIL rst_mid_pending: pairs left=%0d ovf=%0d required 0/0", exp_q.size(), ovf_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int mark;
        int use_lat;
        logic [DATA_W-1:0] vals [8];
        vals = '{24'h010203, 24'h040506, 24'h0708F9, 24'hFAFBFC,
                 24'hFFFFFF, 24'h000000, 24'h5555AA, 24'hAA5555};

        // Phase 1: ready tied high, four back-to-back frames.
        do_reset();
        clear_counts();
        sample_ready = 1'b1;
        add_slot(1'b1, 32'h0, 24, 1'b0);
        for (int f = 0; f < 4; f++) begin
            add_slot(1'b0, {8'h0, vals[2*f]},   24, 1'b0);
            add_slot(1'b1, {8'h0, vals[2*f+1]}, 24, 1'b0);
            push_pair(vals[2*f], vals[2*f+1]);
        end
        mark = ws_q.size();
        add_slot(1'b0, 32'h0, 2, 1'b0);
        lat_found = 1'b0;
        lat       = 0;
        fork
            begin
                @(mark_ev);
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    if (sample_valid) begin
                        lat       = cyc - mark_cyc;
                        lat_found = 1'b1;
                        break;
                    end
                end
            end
        join_none
        send_stream(-1, mark);
        wait_clk(10);
        checks++;
        if (!lat_found || lat > 5) begin
            errors++; $display("FAIL b2b_latency: found=%0b clk=%0d required found and <=5", lat_found, lat);
        end
        checks++;
        if (vcnt != 4) begin errors++; $display("FAIL b2b_valid_pulses: got %0d required 4", vcnt); end
        checks++;
        if (exp_q.size() != 0 || ovf_cnt != 0) begin
            errors++; $display("FAIL b2b_pending: pairs left=%0d ovf=%0d required 0/0", exp_q.size(), ovf_cnt);
        end

        // Phase 2: handshake lands on the clk the next pair forms.
        use_lat = (lat_found && lat >= 1) ? lat : 3;
        clear_counts();
        sample_ready = 1'b0;
        add_slot(1'b1, 32'h0,      24, 1'b0);
        add_slot(1'b0, 32'h9ABCDE, 24, 1'b0);
        add_slot(1'b1, 32'h13F13F, 24, 1'b0);
        add_slot(1'b0, 32'h246810, 24, 1'b0);
        add_slot(1'b1, 32'hACE135, 24, 1'b0);
        mark = ws_q.size();
        add_slot(1'b0, 32'h0, 2, 1'b0);
        push_pair(24'h9ABCDE, 24'h13F13F);
        push_pair(24'h246810, 24'hACE135);
        fork
            begin
                @(mark_ev);
                while (cyc < mark_cyc + use_lat - 1) begin
                    @(posedge clk);
                    #1;
                end
                sample_ready = 1'b1;
                @(posedge clk);
                #1;
                sample_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (sample_valid !== 1'b1 || sample_left !== 24'h246810 || sample_right !== 24'hACE135) begin
                    errors++;
                    $display("FAIL b2b_continuous: valid=%b l=%h r=%h required 1 246810 ace135",
                             sample_valid, sample_left, sample_right);
                end
            end
        join_none
        send_stream(-1, mark);
        wait_clk(10);
        checks++;
        if (ovf_cnt != 0) begin errors++; $display("FAIL b2b_coincide_ovf: got %0d required 0", ovf_cnt); end
        sample_ready = 1'b1;
        wait_clk(1);
        sample_ready = 1'b0;
        wait_clk(3);
        checks++;
        if (exp_q.size() != 0 || sample_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_coincide_pending: pairs left=%0d valid=%b required 0/0",
                               exp_q.size(), sample_valid);
        end
    endtask

    // -----------------------------------------------------------------------
    // Sequencer and watchdog
    // -----------------------------------------------------------------------
    initial begin
        test_reset();
        test_48fs();
        test_64fs_padding();
        test_overflow();
        test_frame_err();
        test_reset_mid_word();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
